// File: rtl/dual_port_mem_responder.sv
// ---------------------------------------------------------------------------
// dual_port_mem_responder
//
// Memory-side responder for the pipeline's two requester ports. Port A is the
// instruction-fetch port (read only) and port B is the data port (read or
// masked write). Both ports are serialised onto one downstream memory
// interface. Every port that took part in a transaction group is acknowledged
// in the same cycle, because the pipeline only advances once all of its
// outstanding ports have been answered together.
//
// Parameters:
//   WIDTH    data/address width in bits
//   B_FIRST  nonzero: serve B before A when both request; zero: A before B
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   read_a            port A read request, held until resp_a
//   address_a         port A word address
//   resp_a, rdata_a   port A one-cycle completion pulse and read data
//   read_b, write_b   port B read / write request, held until resp_b
//   address_b         port B word-aligned address
//   wmask_b, wdata_b  port B byte enables and write data
//   resp_b, rdata_b   port B one-cycle completion pulse and read data
//   mem_read          downstream read request
//   mem_write         downstream write request
//   mem_address       downstream address
//   mem_wdata         downstream write data
//   mem_wmask         downstream byte enables
//   mem_rdata         downstream read data, valid with mem_resp
//   mem_resp          downstream one-cycle completion pulse
// ---------------------------------------------------------------------------
module dual_port_mem_responder #(
  parameter int WIDTH   = 32,
  parameter int B_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_a,
  input  logic [WIDTH-1:0] address_a,
  output logic             resp_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             read_b,
  input  logic             write_b,
  input  logic [WIDTH-1:0] address_b,
  input  logic [3:0]       wmask_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             resp_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_resp
);

  localparam bit BFirst = (B_FIRST != 0);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic             pendA_q, pendA_d;
  logic             pendB_q, pendB_d;
  logic             bWrite_q, bWrite_d;
  logic [WIDTH-1:0] addrA_q, addrA_d;
  logic [WIDTH-1:0] addrB_q, addrB_d;
  logic [3:0]       wmaskB_q, wmaskB_d;
  logic [WIDTH-1:0] wdataB_q, wdataB_d;
  logic [WIDTH-1:0] dataA_q, dataA_d;
  logic [WIDTH-1:0] dataB_q, dataB_d;
  logic             respA_q, respA_d;
  logic             respB_q, respB_d;
  logic [WIDTH-1:0] rdataA_q, rdataA_d;
  logic [WIDTH-1:0] rdataB_q, rdataB_d;
  logic             memRead_q, memRead_d;
  logic             memWrite_q, memWrite_d;
  logic [WIDTH-1:0] memAddress_q, memAddress_d;
  logic [WIDTH-1:0] memWdata_q, memWdata_d;
  logic [3:0]       memWmask_q, memWmask_d;

  // Next-state logic. The first case walks the transaction: accept a group
  // in IDLE, serve the pending ports one after another, then acknowledge.
  // The second case decodes every registered output from the state being
  // entered, so the downstream request and the resp pulses come straight
  // out of flops. Decoding from the next state is what lets a second
  // downstream request follow the first with no idle cycle in between.
  always_comb begin
    state_d      = state_q;
    pendA_d      = pendA_q;
    pendB_d      = pendB_q;
    bWrite_d     = bWrite_q;
    addrA_d      = addrA_q;
    addrB_d      = addrB_q;
    wmaskB_d     = wmaskB_q;
    wdataB_d     = wdataB_q;
    dataA_d      = dataA_q;
    dataB_d      = dataB_q;
    rdataA_d     = rdataA_q;
    rdataB_d     = rdataB_q;
    respA_d      = 1'b0;
    respB_d      = 1'b0;
    memRead_d    = 1'b0;
    memWrite_d   = 1'b0;
    memAddress_d = '0;
    memWdata_d   = '0;
    memWmask_d   = '0;

    case (state_q)
      IDLE: begin
        if (read_a || read_b || write_b) begin
          pendA_d  = read_a;
          pendB_d  = read_b || write_b;
          // read_b together with write_b is served as a write
          bWrite_d = write_b;
          addrA_d  = address_a;
          addrB_d  = address_b;
          wmaskB_d = wmask_b;
          wdataB_d = wdata_b;
          dataA_d  = '0;
          dataB_d  = '0;
          if ((read_b || write_b) && (BFirst || !read_a)) begin
            state_d = SERVE_B;
          end else begin
            state_d = SERVE_A;
          end
        end
      end
      SERVE_A: begin
        if (mem_resp) begin
          dataA_d = mem_rdata;
          state_d = (!BFirst && pendB_q) ? SERVE_B : RESP;
        end
      end
      SERVE_B: begin
        if (mem_resp) begin
          dataB_d = bWrite_q ? '0 : mem_rdata;
          state_d = (BFirst && pendA_q) ? SERVE_A : RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        pendA_d = 1'b0;
        pendB_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      SERVE_A: begin
        memRead_d    = 1'b1;
        memAddress_d = addrA_d;
      end
      SERVE_B: begin
        memAddress_d = addrB_d;
        if (bWrite_d) begin
          memWrite_d = 1'b1;
          memWdata_d = wdataB_d;
          memWmask_d = wmaskB_d;
        end else begin
          memRead_d  = 1'b1;
        end
      end
      RESP: begin
        respA_d  = pendA_d;
        respB_d  = pendB_d;
        rdataA_d = dataA_d;
        rdataB_d = dataB_d;
      end
      default: begin
      end
    endcase
  end

  // State and output registers. Reset abandons any downstream request at
  // once and suppresses all acknowledgements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pendA_q      <= 1'b0;
      pendB_q      <= 1'b0;
      bWrite_q     <= 1'b0;
      addrA_q      <= '0;
      addrB_q      <= '0;
      wmaskB_q     <= '0;
      wdataB_q     <= '0;
      dataA_q      <= '0;
      dataB_q      <= '0;
      respA_q      <= 1'b0;
      respB_q      <= 1'b0;
      rdataA_q     <= '0;
      rdataB_q     <= '0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      memAddress_q <= '0;
      memWdata_q   <= '0;
      memWmask_q   <= '0;
    end else begin
      state_q      <= state_d;
      pendA_q      <= pendA_d;
      pendB_q      <= pendB_d;
      bWrite_q     <= bWrite_d;
      addrA_q      <= addrA_d;
      addrB_q      <= addrB_d;
      wmaskB_q     <= wmaskB_d;
      wdataB_q     <= wdataB_d;
      dataA_q      <= dataA_d;
      dataB_q      <= dataB_d;
      respA_q      <= respA_d;
      respB_q      <= respB_d;
      rdataA_q     <= rdataA_d;
      rdataB_q     <= rdataB_d;
      memRead_q    <= memRead_d;
      memWrite_q   <= memWrite_d;
      memAddress_q <= memAddress_d;
      memWdata_q   <= memWdata_d;
      memWmask_q   <= memWmask_d;
    end
  end

  assign resp_a      = respA_q;
  assign resp_b      = respB_q;
  assign rdata_a     = rdataA_q;
  assign rdata_b     = rdataB_q;
  assign mem_read    = memRead_q;
  assign mem_write   = memWrite_q;
  assign mem_address = memAddress_q;
  assign mem_wdata   = memWdata_q;
  assign mem_wmask   = memWmask_q;

endmodule

// File: doc/dual_port_mem_responder.md
Name: dual_port_mem_responder

Overview:
- Memory-side responder for the pipeline's two requester ports: port A is instruction fetch (read only), port B is data (read/write with byte mask).
- Serialises both ports onto a single downstream memory interface (cache or cacheline adaptor).
- Returns responses so that every port that requested in a transaction group gets `resp` in the same cycle. This matters because the pipeline advances only when all of its outstanding ports are acknowledged together.

Parameters:
- WIDTH, 32, data and address width in bits.
- B_FIRST, 1, when both ports request: 1 serves B then A; 0 serves A then B.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- read_a  in  1  port A read request; held until resp_a.
- address_a  in  WIDTH  port A word address.
- resp_a  out  1  port A completion, one-cycle pulse.
- rdata_a  out  WIDTH  port A read data, valid when resp_a=1.
- read_b  in  1  port B read request.
- write_b  in  1  port B write request.
- address_b  in  WIDTH  port B word-aligned address.
- wmask_b  in  4  port B byte enables.
- wdata_b  in  WIDTH  port B write data.
- resp_b  out  1  port B completion, one-cycle pulse.
- rdata_b  out  WIDTH  port B read data, valid when resp_b=1.
- mem_read  out  1  downstream read request.
- mem_write  out  1  downstream write request.
- mem_address  out  WIDTH  downstream address.
- mem_wdata  out  WIDTH  downstream write data.
- mem_wmask  out  4  downstream byte enables.
- mem_rdata  in  WIDTH  downstream read data, valid with mem_resp.
- mem_resp  in  1  downstream completion, one-cycle pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - All outputs are 0: resp_a, resp_b, rdata_a, rdata_b, mem_read, mem_write, mem_address, mem_wdata, mem_wmask.
  - Pending flags and latched requests are cleared.
- Reset mid-transaction: the downstream request drops immediately and no resp is produced. The downstream side must tolerate an abandoned request.
- States: IDLE, SERVE_A, SERVE_B, RESP.
- IDLE:
  - On the first edge where read_a | read_b | write_b is high, set pend_a = read_a and pend_b = read_b | write_b.
  - Latch address_a, address_b, wmask_b, wdata_b and the B opcode.
  - Next state is the first pending port per B_FIRST.
  - No request: stay in IDLE with all outputs low.
- SERVE_x: the mem_* outputs are driven from the latched request (outputs are decoded from state).
  - SERVE_A: mem_read=1, mem_address=latched A address.
  - SERVE_B, read: mem_read=1.
  - SERVE_B, write: mem_write=1, with latched mask and data.
  - The request holds until mem_resp.
  - On mem_resp, capture mem_rdata into the port's data register; for a write the port's data register is 0.
  - Then go to the other pending port's SERVE state if that port is still unserved, otherwise go to RESP.
  - There is no idle gap between back-to-back downstream requests.
- RESP (exactly one cycle):
  - resp_a = pend_a, resp_b = pend_b, both in this same cycle.
  - rdata_a and rdata_b come from the captured registers and are held stable until the next RESP.
  - Next state is IDLE.
- Requests arriving during SERVE or RESP are not sampled; they are picked up in IDLE. The requester holds them until acknowledged.
- read_b and write_b both high: treated as a write; rdata_b=0.
- Latency (1-cycle downstream memory):
  - Request seen in IDLE at cycle 0 → SERVE at cycle 1 → resp at cycle 2 → IDLE at cycle 3.
  - Dual-port request: resp at cycle 3.
- mem_resp arriving while in IDLE or RESP is ignored.

Test Plan:
- A-only read: read_a=1, address_a=0x60, memory returns 0x00000013 after 1 cycle → mem_read with address 0x60 in cycle 1; resp_a=1 and rdata_a=0x13 in cycle 2; resp_b=0.
- Concurrent requests, B_FIRST=1: read_a@0x64 and read_b@0x100 (mem 0xDEADBEEF), 2-cycle memory latency →
  - mem_address is 0x100 then 0x64 in order.
  - resp_a and resp_b rise in the same single cycle.
  - rdata_b=0xDEADBEEF.
- Masked write: write_b=1, address_b=0x200, wmask_b=4'b0011, wdata_b=0x0000ABCD → mem_write=1 with mask 0011 and data 0xABCD held until mem_resp; resp_b pulses once; rdata_b=0.
- Back-to-back fetch: read_a held high, address changes 0x60 → 0x64 after each resp_a → each address is issued exactly once; no duplicate mem_read for a stale address.
- Reset mid-op: rst=0 while in SERVE_B with mem_write=1 → mem_write, resp_a and resp_b drop to 0 in the same cycle. After rst=1 and a new read_a, normal service resumes.
- Illegal opcode combination: read_b=1 and write_b=1 at 0x300 → a single mem_write and no mem_read; resp_b=1, rdata_b=0.
